sti_feed_ctrl: RTL and testbench

STI_FEED_CTRL -- requirements
Module: sti_feed_ctrl

---
 rtl/sti_pkg.sv | 34 +++
 rtl/sti_req_fifo.sv | 81 ++++++++
 rtl/sti_feed_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sti_feed_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared definitions for the STI feed controller.
//   sti_state_e  : controller FSM states
//   Cfg*         : bit positions inside the 6-bit request configuration field
//                  {last, length[1:0], fill, msb, low}
//   len_to_bits  : STI length code -> expected serial bit count, 8*(len+1)
package sti_pkg;

    localparam int unsigned DataW  = 16;
    localparam int unsigned CfgW   = 6;
    localparam int unsigned EntryW = DataW + CfgW;

    localparam int unsigned CfgLow   = 0;
    localparam int unsigned CfgMsb   = 1;
    localparam int unsigned CfgFill  = 2;
    localparam int unsigned CfgLenLo = 3;
    localparam int unsigned CfgLenHi = 4;
    localparam int unsigned CfgLast  = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StShift,
        StGap,
        StHalt
    } sti_state_e;

    function automatic logic [5:0] len_to_bits(input logic [1:0] len);
        logic [2:0] bytes;
        bytes = {1'b0, len} + 3'd1;
        return {bytes, 3'b000};
    endfunction

endpackage

// File: rtl/sti_req_fifo.sv
// Request buffer ahead of the STI_DAC load port.
//   clk, reset   : clock, asynchronous active-high reset (empties the buffer)
//   push, wdata  : write strobe and word; ignored while full
//   pop          : read strobe; ignored while empty
//   rdata        : word at the head of the buffer (valid while !empty)
//   full, empty  : occupancy flags
// Push and pop in the same cycle are both honoured.
module sti_req_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sti_feed_ctrl.sv
// Feeds buffered request words to an STI_DAC and supervises its serial output.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake; req_data word, req_cfg
//                         {last, length[1:0], fill, msb, low}
//   load                : one-cycle load strobe to STI_DAC
//   pi_*                : word and configuration presented to STI_DAC
//   pi_end              : sticky final-word flag, raised on the last word's load
//   so_valid            : STI serial-output valid, monitored in WAIT/SHIFT only
//   busy                : FSM not idle or buffer non-empty
//   err_len, err_tmo    : sticky burst-length mismatch / so_valid start timeout
//   word_cnt            : completed words, wraps
module sti_feed_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_data,
    input  logic [5:0]  req_cfg,
    output logic        load,
    output logic [15:0] pi_data,
    output logic [1:0]  pi_length,
    output logic        pi_fill,
    output logic        pi_msb,
    output logic        pi_low,
    output logic        pi_end,
    input  logic        so_valid,
    output logic        busy,
    output logic        err_len,
    output logic        err_tmo,
    output logic [7:0]  word_cnt
);

    import sti_pkg::*;

    localparam int unsigned TmoW = $clog2(TMO_CYCLES + 1);

    sti_state_e        state_q, state_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic              err_len_q, err_len_d;
    logic              err_tmo_q, err_tmo_d;
    logic              pi_end_q, pi_end_d;
    logic              cur_last_q;
    logic [15:0]       pi_data_q;
    logic [1:0]        pi_length_q;
    logic              pi_fill_q, pi_msb_q, pi_low_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntryW-1:0] fifo_rdata;
    logic [CfgW-1:0]   head_cfg;

    // Held low during reset so the upstream never sees a ready buffer then.
    assign req_ready = ~fifo_full & ~reset;
    assign fifo_push = req_valid & req_ready;
    assign head_cfg  = fifo_rdata[EntryW-1:DataW];

    sti_req_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EntryW)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({req_cfg, req_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        err_len_d  = err_len_q;
        err_tmo_d  = err_tmo_q;
        pi_end_d   = pi_end_q;
        fifo_pop   = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StLoad;
                    if (head_cfg[CfgLast]) begin
                        pi_end_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                load      = 1'b1;
                tmo_cnt_d = '0;
                state_d   = StWait;
            end
            StWait: begin
                if (so_valid) begin
                    // The first valid bit is seen here, so SHIFT starts at 1.
                    bit_cnt_d = 6'd1;
                    state_d   = StShift;
                end else if (tmo_cnt_q == TmoW'(TMO_CYCLES - 1)) begin
                    err_tmo_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StShift: begin
                if (so_valid) begin
                    // Saturate rather than wrap so a runaway burst still mismatches.
                    if (bit_cnt_q != 6'h3f) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else begin
                    if (bit_cnt_q != len_to_bits(pi_length_q)) begin
                        err_len_d = 1'b1;
                    end
                    word_cnt_d = word_cnt_q + 8'd1;
                    state_d    = cur_last_q ? StHalt : StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tmo_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            pi_end_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
            pi_end_q   <= pi_end_d;
        end
    end

    // Presented word holds from one pop to the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pi_data_q   <= '0;
            pi_length_q <= '0;
            pi_fill_q   <= 1'b0;
            pi_msb_q    <= 1'b0;
            pi_low_q    <= 1'b0;
            cur_last_q  <= 1'b0;
        end else if (fifo_pop) begin
            pi_data_q   <= fifo_rdata[DataW-1:0];
            pi_length_q <= head_cfg[CfgLenHi:CfgLenLo];
            pi_fill_q   <= head_cfg[CfgFill];
            pi_msb_q    <= head_cfg[CfgMsb];
            pi_low_q    <= head_cfg[CfgLow];
            cur_last_q  <= head_cfg[CfgLast];
        end
    end

    assign pi_data   = pi_data_q;
    assign pi_length = pi_length_q;
    assign pi_fill   = pi_fill_q;
    assign pi_msb    = pi_msb_q;
    assign pi_low    = pi_low_q;
    assign pi_end    = pi_end_q;
    assign busy      = (state_q != StIdle) | ~fifo_empty;
    assign err_len   = err_len_q;
    assign err_tmo   = err_tmo_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_sti_feed_ctrl.sv
// Self-checking bench for sti_feed_ctrl. A transaction-level model predicts, for each
// popped word, the load cycle, the so_valid window the bench will drive, and the cycle
// its completion (or timeout) becomes visible; all outputs are compared every cycle.
module tb_sti_feed_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int NEVER = 32'h3fffffff;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [5:0]  req_cfg = '0;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill, pi_msb, pi_low, pi_end;
    logic        so_valid = 1'b0;
    logic        busy, err_len, err_tmo;
    logic [7:0]  word_cnt;

    always #5 clk = ~clk;

    sti_feed_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_cfg   (req_cfg),
        .load      (load),
        .pi_data   (pi_data),
        .pi_length (pi_length),
        .pi_fill   (pi_fill),
        .pi_msb    (pi_msb),
        .pi_low    (pi_low),
        .pi_end    (pi_end),
        .so_valid  (so_valid),
        .busy      (busy),
        .err_len   (err_len),
        .err_tmo   (err_tmo),
        .word_cnt  (word_cnt)
    );

    int checks = 0;
    int passed = 0;

    // Model state; every value describes the current cycle `cyc`.
    logic [21:0] m_q[$];
    int          plan_d[$], plan_n[$];   // directed so_valid scenarios; d >= TMO = silent
    int          cyc, idle_at, load_cyc, done_cyc, tmo_cyc;
    int          burst_lo, burst_hi, win_lo, win_hi;
    logic [15:0] e_data;
    logic [1:0]  e_len;
    logic        e_fill, e_msb, e_low, e_end, e_errlen, e_errtmo, pend_bad;
    logic [7:0]  e_wcnt;
    int          last_load_cyc, load_pulses;
    logic        ready_low_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_q.delete(); plan_d.delete(); plan_n.delete();
        cyc = 0; idle_at = 0; load_cyc = -1; done_cyc = -1; tmo_cyc = -1;
        burst_lo = -1; burst_hi = -2; win_lo = -1; win_hi = -2;
        e_data = '0; e_len = '0; e_fill = 0; e_msb = 0; e_low = 0; e_end = 0;
        e_errlen = 0; e_errtmo = 0; pend_bad = 0; e_wcnt = '0;
        last_load_cyc = -1; load_pulses = 0; ready_low_seen = 0;
    endtask

    task automatic compare_all();
        if (load) begin last_load_cyc = cyc; load_pulses++; end
        if (!req_ready) ready_low_seen = 1;
        chk("load", 32'(load), 32'(cyc == load_cyc));
        chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
        chk("busy", 32'(busy), 32'((cyc < idle_at) || (m_q.size() > 0)));
        chk("pi_data", 32'(pi_data), 32'(e_data));
        chk("pi_length", 32'(pi_length), 32'(e_len));
        chk("pi_cfg_bits", 32'({pi_fill, pi_msb, pi_low}), 32'({e_fill, e_msb, e_low}));
        chk("pi_end", 32'(pi_end), 32'(e_end));
        chk("err_len", 32'(err_len), 32'(e_errlen));
        chk("err_tmo", 32'(err_tmo), 32'(e_errtmo));
        chk("word_cnt", 32'(word_cnt), 32'(e_wcnt));
    endtask

    // One clock: check this cycle, drive so_valid, predict the next edge, advance.
    task automatic step(output logic pushed);
        logic        pop;
        logic [21:0] w;
        int          d, n, e, wc, r;
        compare_all();
        if (cyc >= burst_lo && cyc <= burst_hi) so_valid = 1'b1;
        else if (cyc >= win_lo && cyc <= win_hi) so_valid = 1'b0;
        else so_valid = 1'($urandom_range(0, 1));   // ignored outside WAIT/SHIFT
        pop    = (cyc >= idle_at) && (m_q.size() > 0);
        pushed = req_valid && (m_q.size() < DEPTH);
        if (pop) begin
            w = m_q.pop_front();
            e = cyc + 1;
            e_data = w[15:0]; e_low = w[16]; e_msb = w[17]; e_fill = w[18];
            e_len = w[20:19];
            if (w[21]) e_end = 1'b1;
            load_cyc = e;
            if (plan_d.size() > 0) begin
                d = plan_d.pop_front(); n = plan_n.pop_front();
            end else begin
                r = int'($urandom_range(0, 9));
                d = (r == 0) ? TMO : int'($urandom_range(0, 5));
                n = (r == 1) ? int'($urandom_range(1, 40)) : 8 * (int'(e_len) + 1);
            end
            win_lo = e + 1;
            if (d >= TMO) begin
                burst_lo = -1; burst_hi = -2; win_hi = e + TMO;
                tmo_cyc = e + TMO + 1; idle_at = e + TMO + 1; done_cyc = -1;
            end else begin
                wc = e + 1 + d;
                burst_lo = wc; burst_hi = wc + n - 1; win_hi = wc + n;
                done_cyc = wc + n + 1;
                pend_bad = (n != 8 * (int'(e_len) + 1));
                idle_at  = w[21] ? NEVER : done_cyc + 1;
            end
        end
        if (pushed) m_q.push_back({req_cfg, req_data});
        @(negedge clk);
        cyc++;
        if (cyc == done_cyc) begin
            e_wcnt++;
            if (pend_bad) e_errlen = 1'b1;
        end
        if (cyc == tmo_cyc) e_errtmo = 1'b1;
    endtask

    task automatic run(input int n);
        logic dummy;
        repeat (n) step(dummy);
    endtask

    task automatic push_word(input logic [15:0] d, input logic [5:0] c);
        logic got;
        int   guard;
        req_valid = 1'b1; req_data = d; req_cfg = c; got = 1'b0; guard = 0;
        while (!got && guard < 300) begin step(got); guard++; end
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            $display("FAIL push_accept: no acceptance after %0d cycles, required within 300", guard);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pi_data", 32'(pi_data), 32'd0);
        chk("rst_pi_cfg", 32'({pi_length, pi_fill, pi_msb, pi_low, pi_end}), 32'd0);
        chk("rst_errs", 32'({err_len, err_tmo}), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        req_valid = 1'b0; so_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);
        model_reset();
    endtask

    initial begin
        int   p, guard;
        logic [4:0] rc;
        model_reset();
        @(negedge clk);

        // Single word, exact 8-bit burst; also pins load latency.
        do_reset();
        plan_d.push_back(0); plan_n.push_back(8);
        push_word(16'hA5C3, 6'b000000);
        p = cyc;
        run(30);
        chk("t1_latency", 32'(last_load_cyc - p), 32'd1);
        chk("t1_load_pulses", 32'(load_pulses), 32'd1);
        chk("t1_pi_data", 32'(pi_data), 32'hA5C3);
        chk("t1_word_cnt", 32'(word_cnt), 32'd1);
        chk("t1_err_len", 32'(err_len), 32'd0);

        // Length code 3 expects 32 bits; 31 is a mismatch, and the flag is sticky.
        do_reset();
        plan_d.push_back(0); plan_n.push_back(31);
        plan_d.push_back(2); plan_n.push_back(8);
        push_word(16'h1234, 6'b011000);
        run(60);
        chk("t2_err_len", 32'(err_len), 32'd1);
        chk("t2_word_cnt", 32'(word_cnt), 32'd1);
        push_word(16'h5678, 6'b000101);
        run(40);
        chk("t2_err_len_sticky", 32'(err_len), 32'd1);
        chk("t2_word_cnt2", 32'(word_cnt), 32'd2);

        // Silent STI: timeout after 16 WAIT cycles, next word still loads.
        do_reset();
        plan_d.push_back(TMO); plan_n.push_back(0);
        plan_d.push_back(1);   plan_n.push_back(16);
        push_word(16'hDEAD, 6'b000000);
        push_word(16'hBEEF, 6'b001010);
        run(80);
        chk("t3_err_tmo", 32'(err_tmo), 32'd1);
        chk("t3_word_cnt", 32'(word_cnt), 32'd1);
        chk("t3_pi_data", 32'(pi_data), 32'hBEEF);
        chk("t3_err_len", 32'(err_len), 32'd0);

        // Six back-to-back pushes against a slow STI; buffer must fill.
        do_reset();
        for (int i = 0; i < 6; i++) begin plan_d.push_back(10); plan_n.push_back(8); end
        for (int i = 0; i < 6; i++) push_word(16'h0100 + 16'(i), 6'b000100);
        run(200);
        chk("t4_ready_dropped", 32'(ready_low_seen), 32'd1);
        chk("t4_word_cnt", 32'(word_cnt), 32'd6);
        chk("t4_load_pulses", 32'(load_pulses), 32'd6);
        chk("t4_pi_data", 32'(pi_data), 32'h0105);

        // Last word halts the feed; later pushes are buffered, never loaded.
        do_reset();
        plan_d.push_back(0); plan_n.push_back(8);
        plan_d.push_back(0); plan_n.push_back(24);
        push_word(16'h000A, 6'b000000);
        push_word(16'h000B, 6'b110000);
        push_word(16'h000C, 6'b000000);
        push_word(16'h000D, 6'b000000);
        run(120);
        chk("t5_pi_end", 32'(pi_end), 32'd1);
        chk("t5_pi_data", 32'(pi_data), 32'h000B);
        chk("t5_word_cnt", 32'(word_cnt), 32'd2);
        chk("t5_load_pulses", 32'(load_pulses), 32'd2);
        chk("t5_busy", 32'(busy), 32'd1);

        // Reset in the middle of a SHIFT burst.
        do_reset();
        plan_d.push_back(0); plan_n.push_back(20);
        push_word(16'h00EE, 6'b000000);
        run(3);
        guard = 0;
        while (cyc < burst_lo + 5 && guard < 100) begin run(1); guard++; end
        do_reset();

        // Randomized traffic, non-last words, random lengths/delays/timeouts.
        for (int i = 0; i < 800; i++) begin
            logic got;
            req_valid = ($urandom_range(0, 3) == 0);
            req_data  = 16'($urandom_range(0, 65535));
            rc        = 5'($urandom_range(0, 31));
            req_cfg   = {1'b0, rc};
            step(got);
        end
        req_valid = 1'b0;
        run(100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
